// File: rtl/alu_op_decoder.sv
// ----------------------------------------------------------------------------
// alu_op_decoder
// ID-stage decoder. It takes a MIPS32 instruction word from the IF/ID latch
// and produces a registered decode bundle for the EX stage. The bundle holds
// the ALU control code, operand select, immediate, register addresses and the
// memory/branch/writeback controls. Both sides use a valid/ready handshake,
// and flush discards work after a branch redirect.
//
// Ports
//   clk, rst                 rising-edge clock, async active-high reset
//   in_valid / in_ready      upstream handshake (in_ready is combinational)
//   instr                    instruction word, sampled on an input transfer
//   flush                    drop held bundle and any instr accepted this edge
//   out_valid / out_ready    downstream handshake
//   alu_ctrl                 ADD 0, SUB 1, AND 2, OR 3, SLT 4, MUL 5
//   alu_src_imm, imm         operand B select and extended immediate
//   rs_addr, rt_addr         source register addresses
//   dest_addr                writeback register
//   reg_write, mem_read,
//   mem_write, branch        stage controls
//   illegal                  instruction not in the decode table
// ----------------------------------------------------------------------------
module alu_op_decoder #(
   parameter logic [4:0] ILLEGAL_CTRL = 5'b11111
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] instr,
   input  logic        flush,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [4:0]  alu_ctrl,
   output logic        alu_src_imm,
   output logic [31:0] imm,
   output logic [4:0]  rs_addr,
   output logic [4:0]  rt_addr,
   output logic [4:0]  dest_addr,
   output logic        reg_write,
   output logic        mem_read,
   output logic        mem_write,
   output logic        branch,
   output logic        illegal
);

   localparam int unsigned XLEN  = 32;
   localparam int unsigned REG_W = 5;
   localparam int unsigned CTL_W = 5;

   localparam logic [CTL_W-1:0] ALU_ADD = 5'b00000;
   localparam logic [CTL_W-1:0] ALU_SUB = 5'b00001;
   localparam logic [CTL_W-1:0] ALU_AND = 5'b00010;
   localparam logic [CTL_W-1:0] ALU_OR  = 5'b00011;
   localparam logic [CTL_W-1:0] ALU_SLT = 5'b00100;
   localparam logic [CTL_W-1:0] ALU_MUL = 5'b00101;

   localparam logic [5:0] OP_SPECIAL  = 6'b000000;
   localparam logic [5:0] OP_SPECIAL2 = 6'b011100;
   localparam logic [5:0] OP_ADDI     = 6'b001000;
   localparam logic [5:0] OP_SLTI     = 6'b001010;
   localparam logic [5:0] OP_ANDI     = 6'b001100;
   localparam logic [5:0] OP_ORI      = 6'b001101;
   localparam logic [5:0] OP_LW       = 6'b100011;
   localparam logic [5:0] OP_SW       = 6'b101011;
   localparam logic [5:0] OP_BEQ      = 6'b000100;

   localparam logic [5:0] FN_ADD = 6'b100000;
   localparam logic [5:0] FN_SUB = 6'b100010;
   localparam logic [5:0] FN_AND = 6'b100100;
   localparam logic [5:0] FN_OR  = 6'b100101;
   localparam logic [5:0] FN_SLT = 6'b101010;
   localparam logic [5:0] FN_MUL = 6'b000010;

   typedef struct packed {
      logic [CTL_W-1:0] alu_ctrl;
      logic             alu_src_imm;
      logic [XLEN-1:0]  imm;
      logic [REG_W-1:0] rs;
      logic [REG_W-1:0] rt;
      logic [REG_W-1:0] dest;
      logic             reg_write;
      logic             mem_read;
      logic             mem_write;
      logic             branch;
      logic             illegal;
   } bundle_t;

   bundle_t bundle_d;
   bundle_t bundle_q;
   logic    valid_q;
   logic    valid_d;
   logic    in_xfer;
   logic    out_xfer;

   logic [5:0]       op;
   logic [5:0]       fn;
   logic [REG_W-1:0] rd;
   logic [XLEN-1:0]  imm_sx;
   logic [XLEN-1:0]  imm_zx;

   assign op     = instr[31:26];
   assign fn     = instr[5:0];
   assign rd     = instr[15:11];
   assign imm_sx = {{16{instr[15]}}, instr[15:0]};
   assign imm_zx = {16'h0000, instr[15:0]};

   // Handshake: a held bundle blocks input unless it is popped this cycle.
   assign in_ready = !valid_q || out_ready;
   assign in_xfer  = in_valid && in_ready;
   assign out_xfer = valid_q && out_ready;

   // Instruction decode; defaults describe an illegal instruction.
   always_comb begin
      bundle_d          = '0;
      bundle_d.rs       = instr[25:21];
      bundle_d.rt       = instr[20:16];
      bundle_d.dest     = rd;
      bundle_d.imm      = imm_sx;
      bundle_d.alu_ctrl = ILLEGAL_CTRL;
      bundle_d.illegal  = 1'b1;

      case (op)
         OP_SPECIAL: begin
            if (instr == 32'h0000_0000) begin
               // nop (sll $0,$0,0): harmless ADD with no side effects
               bundle_d.alu_ctrl = ALU_ADD;
               bundle_d.illegal  = 1'b0;
            end else begin
               case (fn)
                  FN_ADD: bundle_d.alu_ctrl = ALU_ADD;
                  FN_SUB: bundle_d.alu_ctrl = ALU_SUB;
                  FN_AND: bundle_d.alu_ctrl = ALU_AND;
                  FN_OR:  bundle_d.alu_ctrl = ALU_OR;
                  FN_SLT: bundle_d.alu_ctrl = ALU_SLT;
                  default: bundle_d.alu_ctrl = ILLEGAL_CTRL;
               endcase
               if (bundle_d.alu_ctrl != ILLEGAL_CTRL) begin
                  bundle_d.reg_write = 1'b1;
                  bundle_d.illegal   = 1'b0;
               end
            end
         end
         OP_SPECIAL2: begin
            if (fn == FN_MUL) begin
               bundle_d.alu_ctrl  = ALU_MUL;
               bundle_d.reg_write = 1'b1;
               bundle_d.illegal   = 1'b0;
            end
         end
         OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI: begin
            bundle_d.alu_src_imm = 1'b1;
            bundle_d.reg_write   = 1'b1;
            bundle_d.dest        = instr[20:16];
            bundle_d.illegal     = 1'b0;
            case (op)
               OP_ADDI: bundle_d.alu_ctrl = ALU_ADD;
               OP_SLTI: bundle_d.alu_ctrl = ALU_SLT;
               OP_ANDI: bundle_d.alu_ctrl = ALU_AND;
               default: bundle_d.alu_ctrl = ALU_OR;
            endcase
            // logical immediates zero-extend
            if (op == OP_ANDI || op == OP_ORI) begin
               bundle_d.imm = imm_zx;
            end
         end
         OP_LW: begin
            bundle_d.alu_ctrl    = ALU_ADD;
            bundle_d.alu_src_imm = 1'b1;
            bundle_d.mem_read    = 1'b1;
            bundle_d.reg_write   = 1'b1;
            bundle_d.dest        = instr[20:16];
            bundle_d.illegal     = 1'b0;
         end
         OP_SW: begin
            bundle_d.alu_ctrl    = ALU_ADD;
            bundle_d.alu_src_imm = 1'b1;
            bundle_d.mem_write   = 1'b1;
            bundle_d.dest        = instr[20:16];
            bundle_d.illegal     = 1'b0;
         end
         OP_BEQ: begin
            // compare rs against rt, so operand B stays the register
            bundle_d.alu_ctrl = ALU_SUB;
            bundle_d.branch   = 1'b1;
            bundle_d.illegal  = 1'b0;
         end
         default: begin
            bundle_d.alu_ctrl = ILLEGAL_CTRL;
         end
      endcase
   end

   // Valid next state: flush beats load, load beats pop.
   always_comb begin
      valid_d = valid_q;
      if (flush) begin
         valid_d = 1'b0;
      end else if (in_xfer) begin
         valid_d = 1'b1;
      end else if (out_xfer) begin
         valid_d = 1'b0;
      end
   end

   // Output register; data loads only on an accepted, unflushed instruction.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid_q  <= 1'b0;
         bundle_q <= '0;
      end else begin
         valid_q <= valid_d;
         if (in_xfer && !flush) begin
            bundle_q <= bundle_d;
         end
      end
   end

   assign out_valid   = valid_q;
   assign alu_ctrl    = bundle_q.alu_ctrl;
   assign alu_src_imm = bundle_q.alu_src_imm;
   assign imm         = bundle_q.imm;
   assign rs_addr     = bundle_q.rs;
   assign rt_addr     = bundle_q.rt;
   assign dest_addr   = bundle_q.dest;
   assign reg_write   = bundle_q.reg_write;
   assign mem_read    = bundle_q.mem_read;
   assign mem_write   = bundle_q.mem_write;
   assign branch      = bundle_q.branch;
   assign illegal     = bundle_q.illegal;

endmodule

// File: tb/tb_alu_op_decoder.sv
// ----------------------------------------------------------------------------
// tb_alu_op_decoder
// Directed bench for alu_op_decoder: reset values, decode of each instruction
// class, streaming, backpressure hold, flush, illegal/nop, async reset.
// ----------------------------------------------------------------------------
module tb_alu_op_decoder;

   logic        clk;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] instr;
   logic        flush;
   logic        out_valid;
   logic        out_ready;
   logic [4:0]  alu_ctrl;
   logic        alu_src_imm;
   logic [31:0] imm;
   logic [4:0]  rs_addr;
   logic [4:0]  rt_addr;
   logic [4:0]  dest_addr;
   logic        reg_write;
   logic        mem_read;
   logic        mem_write;
   logic        branch;
   logic        illegal;

   int checks;
   int errors;

   alu_op_decoder dut (
      .clk         (clk),
      .rst         (rst),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .instr       (instr),
      .flush       (flush),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .alu_ctrl    (alu_ctrl),
      .alu_src_imm (alu_src_imm),
      .imm         (imm),
      .rs_addr     (rs_addr),
      .rt_addr     (rt_addr),
      .dest_addr   (dest_addr),
      .reg_write   (reg_write),
      .mem_read    (mem_read),
      .mem_write   (mem_write),
      .branch      (branch),
      .illegal     (illegal)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Present instr with in_valid, then step past the next rising edge.
   task automatic push(input logic [31:0] w);
      instr    = w;
      in_valid = 1'b1;
      @(posedge clk);
      #1;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      checks    = 0;
      errors    = 0;
      rst       = 1'b0;
      in_valid  = 1'b0;
      instr     = 32'h0;
      flush     = 1'b0;
      out_ready = 1'b1;

      // reset values appear immediately, before any clock edge
      #2 rst = 1'b1;
      #1;
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_in_ready",  32'(in_ready),  32'd1);
      chk("rst_alu_ctrl",  32'(alu_ctrl),  32'd0);
      chk("rst_imm",       imm,            32'd0);
      chk("rst_dest",      32'(dest_addr), 32'd0);
      chk("rst_illegal",   32'(illegal),   32'd0);
      chk("rst_reg_write", 32'(reg_write), 32'd0);
      @(posedge clk);
      #1 rst = 1'b0;

      // add $8,$9,$10
      push(32'h012A4020);
      chk("add_valid",   32'(out_valid),   32'd1);
      chk("add_alu",     32'(alu_ctrl),    32'd0);
      chk("add_rs",      32'(rs_addr),     32'd9);
      chk("add_rt",      32'(rt_addr),     32'd10);
      chk("add_dest",    32'(dest_addr),   32'd8);
      chk("add_rw",      32'(reg_write),   32'd1);
      chk("add_srcimm",  32'(alu_src_imm), 32'd0);

      // lw $8,-4($9)
      push(32'h8D28FFFC);
      chk("lw_alu",    32'(alu_ctrl),    32'd0);
      chk("lw_imm",    imm,              32'hFFFFFFFC);
      chk("lw_mr",     32'(mem_read),    32'd1);
      chk("lw_rw",     32'(reg_write),   32'd1);
      chk("lw_dest",   32'(dest_addr),   32'd8);
      chk("lw_srcimm", 32'(alu_src_imm), 32'd1);

      // ori $8,$9,0xFFFF zero-extends
      push(32'h3528FFFF);
      chk("ori_imm", imm,           32'h0000FFFF);
      chk("ori_alu", 32'(alu_ctrl), 32'd3);

      // andi zero-extends a negative-looking immediate
      push(32'h31288000);
      chk("andi_imm", imm,           32'h00008000);
      chk("andi_alu", 32'(alu_ctrl), 32'd2);

      // slti sign-extends
      push(32'h2928FFFF);
      chk("slti_imm", imm,           32'hFFFFFFFF);
      chk("slti_alu", 32'(alu_ctrl), 32'd4);

      // sw: memory write, no register write
      push(32'hAD28FFFC);
      chk("sw_mw",  32'(mem_write), 32'd1);
      chk("sw_rw",  32'(reg_write), 32'd0);
      chk("sw_mr",  32'(mem_read),  32'd0);
      chk("sw_imm", imm,            32'hFFFFFFFC);

      // stream add, sub, slt, mul with no bubbles
      push(32'h012A4020);
      chk("s_add_valid", 32'(out_valid), 32'd1);
      chk("s_add_alu",   32'(alu_ctrl),  32'd0);
      push(32'h012A4022);
      chk("s_sub_valid", 32'(out_valid), 32'd1);
      chk("s_sub_alu",   32'(alu_ctrl),  32'd1);
      push(32'h012A402A);
      chk("s_slt_valid", 32'(out_valid), 32'd1);
      chk("s_slt_alu",   32'(alu_ctrl),  32'd4);
      push(32'h712A4002);
      chk("s_mul_valid", 32'(out_valid), 32'd1);
      chk("s_mul_alu",   32'(alu_ctrl),  32'd5);
      chk("s_mul_rw",    32'(reg_write), 32'd1);
      chk("s_mul_dest",  32'(dest_addr), 32'd8);

      // backpressure: mul bundle held for 3 cycles while 'and' waits
      out_ready = 1'b0;
      instr     = 32'h012A4024;
      in_valid  = 1'b1;
      #1;
      chk("hold_in_ready0", 32'(in_ready), 32'd0);
      for (int i = 0; i < 3; i++) begin
         step();
         chk("hold_valid",    32'(out_valid), 32'd1);
         chk("hold_alu",      32'(alu_ctrl),  32'd5);
         chk("hold_in_ready", 32'(in_ready),  32'd0);
      end
      out_ready = 1'b1;
      #1;
      chk("release_in_ready", 32'(in_ready), 32'd1);
      step();
      chk("release_valid", 32'(out_valid), 32'd1);
      chk("release_alu",   32'(alu_ctrl),  32'd2);
      chk("release_rw",    32'(reg_write), 32'd1);

      // flush together with a beq load drops it
      flush = 1'b1;
      push(32'h11090003);
      chk("flush_valid", 32'(out_valid), 32'd0);
      flush = 1'b0;

      // following instr decodes normally: addi $8,$9,-2
      push(32'h2128FFFE);
      chk("addi_valid",  32'(out_valid),   32'd1);
      chk("addi_alu",    32'(alu_ctrl),    32'd0);
      chk("addi_imm",    imm,              32'hFFFFFFFE);
      chk("addi_dest",   32'(dest_addr),   32'd8);
      chk("addi_srcimm", 32'(alu_src_imm), 32'd1);
      chk("addi_branch", 32'(branch),      32'd0);

      // beq decoded normally
      push(32'h11090003);
      chk("beq_alu",    32'(alu_ctrl),    32'd1);
      chk("beq_branch", 32'(branch),      32'd1);
      chk("beq_rw",     32'(reg_write),   32'd0);
      chk("beq_srcimm", 32'(alu_src_imm), 32'd0);
      chk("beq_imm",    imm,              32'h00000003);

      // illegal opcode
      push(32'hFC000000);
      chk("ill_flag", 32'(illegal),   32'd1);
      chk("ill_alu",  32'(alu_ctrl),  32'd31);
      chk("ill_rw",   32'(reg_write), 32'd0);
      chk("ill_mr",   32'(mem_read),  32'd0);
      chk("ill_mw",   32'(mem_write), 32'd0);
      chk("ill_br",   32'(branch),    32'd0);

      // R-type with unsupported funct (addu)
      push(32'h012A4021);
      chk("illfn_flag", 32'(illegal),  32'd1);
      chk("illfn_alu",  32'(alu_ctrl), 32'd31);
      chk("illfn_rw",   32'(reg_write), 32'd0);

      // nop is legal with no side effects
      push(32'h00000000);
      chk("nop_flag",  32'(illegal),   32'd0);
      chk("nop_alu",   32'(alu_ctrl),  32'd0);
      chk("nop_rw",    32'(reg_write), 32'd0);
      chk("nop_valid", 32'(out_valid), 32'd1);

      // pop without push clears out_valid
      in_valid = 1'b0;
      step();
      chk("pop_valid",    32'(out_valid), 32'd0);
      chk("pop_in_ready", 32'(in_ready),  32'd1);

      // async reset while a bundle is held
      push(32'h012A4020);
      in_valid  = 1'b0;
      out_ready = 1'b0;
      step();
      chk("pre_rst_valid", 32'(out_valid), 32'd1);
      #2 rst = 1'b1;
      #1;
      chk("async_rst_valid",    32'(out_valid), 32'd0);
      chk("async_rst_in_ready", 32'(in_ready),  32'd1);
      chk("async_rst_rw",       32'(reg_write), 32'd0);
      step();
      rst = 1'b0;
      chk("post_rst_in_ready", 32'(in_ready), 32'd1);

      // decode resumes after reset
      out_ready = 1'b1;
      push(32'h012A4022);
      chk("post_rst_valid", 32'(out_valid), 32'd1);
      chk("post_rst_alu",   32'(alu_ctrl),  32'd1);
      in_valid = 1'b0;

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/alu_op_decoder.md
Name: alu_op_decoder

Overview:
- ID-stage producer of the ALU control interface: accepts a fetched MIPS32 instruction word and emits a registered decode bundle for EX.
- Bundle: 5-bit ALU control code, operand select, immediate, register addresses and memory/branch/writeback controls.
- Sits between the IF/ID latch and the ALU, with a valid/ready handshake on both sides and a flush for branch redirects.

Parameters:
- ILLEGAL_CTRL, 5'b11111, ALU control code emitted for undecodable instructions; falls into the ALU default arm and produces 0.

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  instr is valid this cycle
- in_ready  output  1  decoder can accept instr this cycle
- instr  input  32  MIPS32 instruction word
- flush  input  1  discard held output and any instr accepted this cycle
- out_valid  output  1  decode bundle valid
- out_ready  input  1  EX consumes the bundle this cycle
- alu_ctrl  output  5  ADD 00000, SUB 00001, AND 00010, OR 00011, SLT 00100, MUL 00101
- alu_src_imm  output  1  operand B comes from imm, not rt
- imm  output  32  extended immediate
- rs_addr  output  5  instr[25:21]
- rt_addr  output  5  instr[20:16]
- dest_addr  output  5  writeback register
- reg_write, mem_read, mem_write, branch  output  1 each  stage controls
- illegal  output  1  instruction not in the decode table

Behaviour:
- Reset (async, immediate):
  - out_valid=0, illegal=0, all control bits 0.
  - alu_ctrl=00000, imm=0, all addresses 0.
- Handshake:
  - in_ready = !out_valid || out_ready (combinational).
  - Transfer in when in_valid && in_ready; transfer out when out_valid && out_ready.
- Latency and throughput:
  - Exactly 1 cycle: instr accepted at edge N appears at outputs after edge N, out_valid=1.
  - Back-to-back transfers give full throughput when out_ready stays high.
- Hold: while out_valid && !out_ready, all outputs stay stable and in_ready=0.
- Flush:
  - On an edge with flush=1, out_valid becomes 0 regardless of in_valid or out_ready.
  - Flush wins over a simultaneous load; the instr is dropped.
  - The data fields may keep stale values but are don't-care while out_valid=0.
- Register behaviour:
  - The output register loads only on an input transfer.
  - Pop without a push (out transfer, no in transfer) clears out_valid.
- Decode table (op=instr[31:26], fn=instr[5:0]):
  - op 000000, fn 100000/100010/100100/100101/101010 -> ADD/SUB/AND/OR/SLT; reg_write=1, dest=rd (instr[15:11]), alu_src_imm=0.
  - op 011100, fn 000010 (mul) -> MUL; reg_write=1, dest=rd.
  - addi 001000 -> ADD; slti 001010 -> SLT. Both sign-extend imm, dest=rt, reg_write=1, alu_src_imm=1.
  - andi 001100 -> AND; ori 001101 -> OR. Both zero-extend imm, dest=rt, reg_write=1, alu_src_imm=1.
  - lw 100011 -> ADD, sign-extend, mem_read=1, reg_write=1, dest=rt.
  - sw 101011 -> ADD, sign-extend, mem_write=1, reg_write=0.
  - beq 000100 -> SUB, sign-extend, alu_src_imm=0, branch=1, reg_write=0.
  - Everything else -> alu_ctrl=ILLEGAL_CTRL, illegal=1, and all of reg_write, mem_read, mem_write, branch = 0.
  - 32'h00000000 (sll $0, i.e. nop) is treated as illegal=0: alu_ctrl=ADD, all controls 0.
- Reset asserted mid-hold clears out_valid immediately. The first post-reset cycle has in_ready=1.

Test Plan:
- Reset then instr=32'h012A4020 (add $8,$9,$10), out_ready=1 -> next cycle out_valid=1, alu_ctrl=00000, rs=9, rt=10, dest=8, reg_write=1, alu_src_imm=0.
- instr=32'h8D28FFFC (lw $8,-4($9)) -> alu_ctrl=00000, imm=32'hFFFFFFFC, mem_read=1, dest=8, alu_src_imm=1. Then ori 32'h3528FFFF -> imm=32'h0000FFFF, alu_ctrl=00011.
- Stream add, sub, slt, mul (32'h712A4002) with out_ready=1 -> alu_ctrl 00000, 00001, 00100, 00101 on consecutive cycles, no bubbles.
- Hold out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0, outputs frozen. Release -> next instr accepted the same cycle the held bundle pops.
- flush=1 together with in_valid=1 and a beq instr -> out_valid=0 next cycle, instr lost. A following instr decodes normally.
- instr=32'hFC000000 -> illegal=1, alu_ctrl=11111, all write/branch controls 0. Async rst pulse mid-hold -> out_valid=0 before next clk edge.
